ram_controlador: RTL and testbench
==================================

RAM_CONTROLADOR -- requirements
Module: ram_controlador

Interface
REQ-001 The block SHALL have one clock and a reset that is synchronous and active-high; ports SHALL be named as below.
REQ-002 Parameters: none; word count fixed at 4, word width fixed at 4 bits.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 clear  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  requester presents an operation.
REQ-006 req_ready  output  1  controller accepts the operation this cycle.
REQ-007 req_rw  input  1  1 = write, 0 = read.
REQ-008 req_endereco  input  2  word index 0..3.
REQ-009 req_dado  input  4  write data.
REQ-010 resp_valid  output  1  completion available.
REQ-011 resp_ready  input  1  requester takes the completion.
REQ-012 resp_escrita  output  1  1 = completion of a write, 0 = of a read.
REQ-013 resp_dado  output  4  read data for reads; written data for writes.
REQ-014 ram_rw  output  1  write strobe shared by the four 1x4 RAM cells.
REQ-015 ram_endereco  output  4  one-hot cell select; bit i selects word i.
REQ-016 ram_data_entrada  output  4  data bus into the cells.
REQ-017 ram_data_saida  input  4  OR of the cells' outputs; unselected cells drive 0000.
REQ-018 ops_count  output  8  number of completed handshakes.

Function
REQ-019 FSM states SHALL be INICIALIZA, OCIOSO, ESCRITA, LEITURA and RESPOSTA; all ram_* outputs SHALL be registered.
REQ-020 INICIALIZA SHALL sweep words 0,1,2,3 over 4 consecutive cycles with ram_rw=1, the one-hot select of the current word and ram_data_entrada=0000, then go to OCIOSO.
REQ-021 req_ready SHALL be 1 only in OCIOSO; req_valid in any other state SHALL be ignored.
REQ-022 In OCIOSO, ram_rw=0, ram_endereco=0000 and ram_data_entrada=0000.
REQ-023 On req_valid&req_ready (cycle N), the controller SHALL latch rw, address and data and enter ESCRITA (req_rw=1) or LEITURA (req_rw=0).
REQ-024 In ESCRITA (cycle N+1): ram_rw=1, ram_endereco=one-hot(address) and ram_data_entrada=latched data, for exactly one cycle; then go to RESPOSTA with resp_escrita=1 and resp_dado=written data.
REQ-025 In LEITURA (cycle N+1): ram_rw=0 and ram_endereco=one-hot(address); ram_data_saida SHALL be captured into resp_dado at the end of the cycle; then go to RESPOSTA with resp_escrita=0.
REQ-026 In RESPOSTA: resp_valid=1, ram_* outputs are all zero, and resp_dado/resp_escrita are held stable until resp_ready=1.
REQ-027 On resp_valid&resp_ready the controller SHALL return to OCIOSO and increment ops_count modulo 256 (255 -> 0).
REQ-028 Latency SHALL be 2 cycles from acceptance to resp_valid=1; the minimum period between acceptances SHALL be 3 cycles.
REQ-029 resp_valid SHALL be 0 in every state except RESPOSTA.

Reset
REQ-030 When clear=1 at a rising edge, from any state, the controller SHALL enter INICIALIZA with sweep index 0, ops_count=0, resp_valid=0, resp_dado=0000, resp_escrita=0, req_ready=0 and all ram_* outputs=0; any operation in flight is dropped without a response.
REQ-031 If clear is held high, the controller SHALL remain at sweep index 0 and the sweep SHALL start on the first edge after clear falls.

Verification
REQ-032 Release clear -> 4 cycles with ram_rw=1 and ram_endereco 0001, 0010, 0100, 1000 in order, data 0000; req_ready=1 in the fifth cycle.
REQ-033 Write word 2 with 1011, resp_ready=1 -> one cycle with ram_rw=1, ram_endereco=0100, ram_data_entrada=1011; resp_valid 2 cycles after acceptance, resp_escrita=1, resp_dado=1011; ops_count=1.
REQ-034 Read word 2 with the RAM model returning 1011 -> ram_endereco=0100, ram_rw=0; resp_dado=1011, resp_escrita=0.
REQ-035 Hold resp_ready=0 for 5 cycles during a read -> resp_valid and resp_dado stay stable, req_ready=0, and req_valid pulses are ignored.
REQ-036 Assert clear during ESCRITA -> no response is issued, the sweep restarts, and ops_count=0.
REQ-037 Complete 256 operations -> ops_count wraps from 255 to 0.

Source files
------------

// File: rtl/ram_controlador.sv
// ram_controlador
//   Request/response front end for four 1x4 RAM cells. After reset it zeroes
//   all four words, then serves one operation at a time. An operation is
//   accepted in OCIOSO, performed on the cells for one cycle (ESCRITA or
//   LEITURA), and answered in RESPOSTA until the requester takes it.
//
// Ports
//   clock, clear          rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_rw (1=write), req_endereco,
//                         req_dado
//   resp_valid/resp_ready response handshake; resp_escrita (1=write),
//                         resp_dado (read data or written data)
//   ram_rw, ram_endereco, ram_data_entrada
//                         registered strobe, one-hot select and data to cells
//   ram_data_saida        OR of cell outputs (unselected cells drive 0)
//   ops_count             completed handshakes, modulo 256

module ram_controlador (
    input  logic       clock,
    input  logic       clear,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [1:0] req_endereco,
    input  logic [3:0] req_dado,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_escrita,
    output logic [3:0] resp_dado,
    output logic       ram_rw,
    output logic [3:0] ram_endereco,
    output logic [3:0] ram_data_entrada,
    input  logic [3:0] ram_data_saida,
    output logic [7:0] ops_count
);

    localparam logic [2:0] INICIALIZA = 3'd0;
    localparam logic [2:0] OCIOSO     = 3'd1;
    localparam logic [2:0] ESCRITA    = 3'd2;
    localparam logic [2:0] LEITURA    = 3'd3;
    localparam logic [2:0] RESPOSTA   = 3'd4;

    function automatic logic [3:0] onehot(input logic [1:0] a);
        return 4'b0001 << a;
    endfunction

    logic [2:0] state_q, state_d;
    // Sweep index runs 0..4: values 0..3 drive a word, 4 is the cycle in
    // which the last word is on the bus, after which the FSM goes idle.
    logic [2:0] idx_q, idx_d;
    logic [3:0] data_q, data_d;
    logic       resp_escrita_q, resp_escrita_d;
    logic [3:0] resp_dado_q, resp_dado_d;
    logic [7:0] ops_q, ops_d;
    logic       ram_rw_q, ram_rw_d;
    logic [3:0] ram_end_q, ram_end_d;
    logic [3:0] ram_din_q, ram_din_d;

    // RAM outputs are registered, so they are computed from the transition
    // being taken: the values loaded at an edge are what the cells see in
    // the state entered at that edge. The operation's direction lives in
    // the state and the select is registered at acceptance, so only the
    // write data needs a separate latch.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        data_d         = data_q;
        resp_escrita_d = resp_escrita_q;
        resp_dado_d    = resp_dado_q;
        ops_d          = ops_q;
        ram_rw_d       = 1'b0;
        ram_end_d      = 4'b0000;
        ram_din_d      = 4'b0000;

        case (state_q)
            INICIALIZA: begin
                if (idx_q == 3'd4) begin
                    state_d = OCIOSO;
                    idx_d   = 3'd0;
                end else begin
                    ram_rw_d  = 1'b1;
                    ram_end_d = onehot(idx_q[1:0]);
                    idx_d     = idx_q + 3'd1;
                end
            end
            OCIOSO: begin
                if (req_valid) begin
                    data_d    = req_dado;
                    ram_end_d = onehot(req_endereco);
                    if (req_rw) begin
                        state_d   = ESCRITA;
                        ram_rw_d  = 1'b1;
                        ram_din_d = req_dado;
                    end else begin
                        state_d = LEITURA;
                    end
                end
            end
            ESCRITA: begin
                state_d        = RESPOSTA;
                resp_escrita_d = 1'b1;
                resp_dado_d    = data_q;
            end
            LEITURA: begin
                // Cell output is valid while the select is on the bus.
                state_d        = RESPOSTA;
                resp_escrita_d = 1'b0;
                resp_dado_d    = ram_data_saida;
            end
            RESPOSTA: begin
                if (resp_ready) begin
                    state_d = OCIOSO;
                    ops_d   = ops_q + 8'd1;
                end
            end
            default: begin
                state_d = INICIALIZA;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q        <= INICIALIZA;
            idx_q          <= 3'd0;
            data_q         <= 4'b0000;
            resp_escrita_q <= 1'b0;
            resp_dado_q    <= 4'b0000;
            ops_q          <= 8'd0;
            ram_rw_q       <= 1'b0;
            ram_end_q      <= 4'b0000;
            ram_din_q      <= 4'b0000;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            data_q         <= data_d;
            resp_escrita_q <= resp_escrita_d;
            resp_dado_q    <= resp_dado_d;
            ops_q          <= ops_d;
            ram_rw_q       <= ram_rw_d;
            ram_end_q      <= ram_end_d;
            ram_din_q      <= ram_din_d;
        end
    end

    assign req_ready        = (state_q == OCIOSO);
    assign resp_valid       = (state_q == RESPOSTA);
    assign resp_escrita     = resp_escrita_q;
    assign resp_dado        = resp_dado_q;
    assign ops_count        = ops_q;
    assign ram_rw           = ram_rw_q;
    assign ram_endereco     = ram_end_q;
    assign ram_data_entrada = ram_din_q;

endmodule

// File: tb/tb_ram_controlador.sv
module tb_ram_controlador;

    logic       clock = 1'b0;
    logic       clear;
    logic       req_valid, req_ready, req_rw;
    logic [1:0] req_endereco;
    logic [3:0] req_dado;
    logic       resp_valid, resp_ready, resp_escrita;
    logic [3:0] resp_dado;
    logic       ram_rw;
    logic [3:0] ram_endereco, ram_data_entrada, ram_data_saida;
    logic [7:0] ops_count;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ram_controlador dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_endereco(req_endereco), .req_dado(req_dado),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_escrita(resp_escrita), .resp_dado(resp_dado),
        .ram_rw(ram_rw), .ram_endereco(ram_endereco),
        .ram_data_entrada(ram_data_entrada), .ram_data_saida(ram_data_saida),
        .ops_count(ops_count)
    );

    // Four 1x4 cells: write on strobe+select, unselected cells output 0.
    logic [3:0] mem [4];
    always @(posedge clock)
        for (int i = 0; i < 4; i++)
            if (ram_rw && ram_endereco[i]) mem[i] <= ram_data_entrada;
    always_comb begin
        ram_data_saida = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (ram_endereco[i]) ram_data_saida = ram_data_saida | mem[i];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ram_idle(input string tag);
        chk({tag, "_rw"}, {7'd0, ram_rw}, 8'd0);
        chk({tag, "_end"}, {4'd0, ram_endereco}, 8'd0);
        chk({tag, "_din"}, {4'd0, ram_data_entrada}, 8'd0);
    endtask

    // Full write with immediate resp_ready; expects to start in OCIOSO.
    task automatic do_write(input logic [1:0] a, input logic [3:0] d, input bit full);
        req_valid = 1; req_rw = 1; req_endereco = a; req_dado = d; resp_ready = 1;
        tick();
        req_valid = 0;
        if (full) begin
            chk("wr_rw", {7'd0, ram_rw}, 8'd1);
            chk("wr_end", {4'd0, ram_endereco}, {4'd0, 4'b0001 << a});
            chk("wr_din", {4'd0, ram_data_entrada}, {4'd0, d});
            chk("wr_vld_early", {7'd0, resp_valid}, 8'd0);
        end
        tick();
        if (full) begin
            chk("wr_vld", {7'd0, resp_valid}, 8'd1);
            chk("wr_esc", {7'd0, resp_escrita}, 8'd1);
            chk("wr_dado", {4'd0, resp_dado}, {4'd0, d});
            chk_ram_idle("wr_resp");
        end
        tick();
    endtask

    task automatic do_read(input logic [1:0] a, input logic [3:0] exp);
        req_valid = 1; req_rw = 0; req_endereco = a; req_dado = 4'hF; resp_ready = 1;
        tick();
        req_valid = 0;
        chk("rd_rw", {7'd0, ram_rw}, 8'd0);
        chk("rd_end", {4'd0, ram_endereco}, {4'd0, 4'b0001 << a});
        tick();
        chk("rd_vld", {7'd0, resp_valid}, 8'd1);
        chk("rd_esc", {7'd0, resp_escrita}, 8'd0);
        chk("rd_dado", {4'd0, resp_dado}, {4'd0, exp});
        tick();
    endtask

    task automatic check_sweep();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("sw_rw", {7'd0, ram_rw}, 8'd1);
            chk("sw_end", {4'd0, ram_endereco}, 8'd1 << i);
            chk("sw_din", {4'd0, ram_data_entrada}, 8'd0);
            chk("sw_ready", {7'd0, req_ready}, 8'd0);
        end
        tick();
        chk("sw_done_ready", {7'd0, req_ready}, 8'd1);
        chk_ram_idle("sw_done");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 4'hA;
        clear = 1; req_valid = 0; req_rw = 0; req_endereco = 0; req_dado = 0; resp_ready = 0;
        tick(); tick();
        chk("rst_ready", {7'd0, req_ready}, 8'd0);
        chk("rst_vld", {7'd0, resp_valid}, 8'd0);
        chk("rst_ops", ops_count, 8'd0);
        chk("rst_dado", {4'd0, resp_dado}, 8'd0);
        chk("rst_esc", {7'd0, resp_escrita}, 8'd0);
        chk_ram_idle("rst");

        clear = 0;
        check_sweep();

        // Write word 2 then read it back.
        do_write(2'd2, 4'b1011, 1);
        chk("wr_ops", ops_count, 8'd1);
        chk("wr_ready_again", {7'd0, req_ready}, 8'd1);
        do_read(2'd2, 4'b1011);
        chk("rd_ops", ops_count, 8'd2);

        // Read with response stalled; stray requests must be ignored.
        req_valid = 1; req_rw = 0; req_endereco = 2'd2; resp_ready = 0;
        tick();
        req_valid = 0;
        tick();
        chk("st_vld0", {7'd0, resp_valid}, 8'd1);
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0]; req_rw = 1; req_endereco = 2'd0; req_dado = 4'hF;
            tick();
            chk("st_vld", {7'd0, resp_valid}, 8'd1);
            chk("st_dado", {4'd0, resp_dado}, 8'h0B);
            chk("st_esc", {7'd0, resp_escrita}, 8'd0);
            chk("st_ready", {7'd0, req_ready}, 8'd0);
            chk("st_rw", {7'd0, ram_rw}, 8'd0);
        end
        req_valid = 0; resp_ready = 1;
        tick();
        chk("st_ops", ops_count, 8'd3);
        chk("st_vld_done", {7'd0, resp_valid}, 8'd0);

        // More patterns: other words, cleared word stays zero.
        do_write(2'd0, 4'b0101, 1);
        do_read(2'd0, 4'b0101);
        do_read(2'd3, 4'b0000);
        do_write(2'd3, 4'b1111, 1);
        do_read(2'd3, 4'b1111);
        chk("pat_ops", ops_count, 8'd8);

        // Clear while ESCRITA is on the bus.
        req_valid = 1; req_rw = 1; req_endereco = 2'd1; req_dado = 4'b0110; resp_ready = 1;
        tick();
        req_valid = 0;
        chk("cl_in_esc", {7'd0, ram_rw}, 8'd1);
        clear = 1;
        tick();
        chk("cl_vld", {7'd0, resp_valid}, 8'd0);
        chk("cl_ops", ops_count, 8'd0);
        chk("cl_ready", {7'd0, req_ready}, 8'd0);
        chk_ram_idle("cl");
        tick();
        chk("cl_hold_vld", {7'd0, resp_valid}, 8'd0);
        chk_ram_idle("cl_hold");
        clear = 0;
        check_sweep();
        chk("cl_after_ops", ops_count, 8'd0);
        do_read(2'd2, 4'b0000);

        // Counter wrap: 1 done above, 254 more -> 255, then one more -> 0.
        for (int i = 0; i < 254; i++) do_write(2'(i), 4'(i), 0);
        chk("wrap_255", ops_count, 8'd255);
        do_write(2'd1, 4'b1001, 0);
        chk("wrap_0", ops_count, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
